plaintext_store: RTL and testbench

- Downstream stage of crypto_engine. Captures the decrypted blocks that the engine emits on its dout/dout_valid/addr interface.
- Buffers them in a small ingress FIFO, then commits them into a DEPTH-entry plaintext memory with a per-entry valid bitmap.
- Consumers read from that memory through a request/response port.
- A zeroise command scrubs all plaintext so secrets do not persist after a session (TEE requirement).

---
 rtl/plaintext_store.sv | 149 ++++++++++++++
 tb/tb_plaintext_store.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/plaintext_store.sv
// rtl/plaintext_store.sv - plaintext capture FIFO, entry memory with valid bitmap, read port and zeroise scrub
//
// Optional feature macro: PTSTORE_FILL_COUNT_EN (adds fill_count_o).
//
// Ports:
//   clock_i, reset_ni          : clock (rising edge), asynchronous active-low reset
//   in_data_i/in_valid_i/in_addr_i, in_ready_o : decrypted block ingress from the engine
//   overflow_o                 : sticky, a block was offered while in_ready_o was low
//   rd_req_i/rd_addr_i, rd_ready_o : read request / acceptance
//   rd_valid_o/rd_data_o/rd_err_o  : one-cycle read response, rd_err_o marks an unwritten entry
//   zeroise_i, busy_o          : scrub request pulse / scrub in progress
//   fill_count_o               : number of valid entries (PTSTORE_FILL_COUNT_EN only)
module plaintext_store #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 2048,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic                     in_valid_i,
    input  logic [$clog2(DEPTH)-1:0] in_addr_i,
    output logic                     in_ready_o,
    output logic                     overflow_o,
    input  logic                     rd_req_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic                     rd_ready_o,
    output logic                     rd_valid_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_err_o,
`ifdef PTSTORE_FILL_COUNT_EN
    output logic [$clog2(DEPTH):0]   fill_count_o,
`endif
    input  logic                     zeroise_i,
    output logic                     busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] FIFO_FULL = (FW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SCRUB} state_t;

    state_t            state_q, state_d;
    logic [FW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     fifo_addr_q [FIFO_DEPTH];
    logic [WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]  bitmap_q;
    logic [AW-1:0]     idx_q;
    logic              in_ready_q, rd_ready_q;
    logic              overflow_q, rd_valid_q, rd_err_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic [AW-1:0]     head_addr;
    logic [WIDTH-1:0]  head_data;
    logic              zero_acc, fifo_empty, push, pop, rd_acc;
    logic [FW:0]       fifo_cnt_d;

    assign head_addr = fifo_addr_q[rd_ptr_q[FW-1:0]];
    assign head_data = fifo_data_q[rd_ptr_q[FW-1:0]];

    // State register
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state and datapath control
    always_comb begin
        zero_acc   = (state_q == IDLE) && zeroise_i;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        push       = in_valid_i && in_ready_q && !zero_acc;
        pop        = (state_q == IDLE) && !fifo_empty && !zero_acc;
        rd_acc     = rd_req_i && rd_ready_q && !zero_acc;
        state_d    = state_q;
        case (state_q)
            IDLE:    if (zero_acc) state_d = SCRUB;
            SCRUB:   if (idx_q == AW'(DEPTH-1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Zeroise discards everything still queued
        wr_ptr_d   = zero_acc ? '0 : wr_ptr_q + (push ? (FW+1)'(1) : '0);
        rd_ptr_d   = zero_acc ? '0 : rd_ptr_q + (pop  ? (FW+1)'(1) : '0);
        fifo_cnt_d = wr_ptr_d - rd_ptr_d;
    end

    // Outputs; zeroise pre-empts read acceptance in the same cycle
    always_comb begin
        busy_o     = (state_q == SCRUB);
        in_ready_o = in_ready_q;
        rd_ready_o = rd_ready_q && !zeroise_i;
        overflow_o = overflow_q;
        rd_valid_o = rd_valid_q;
        rd_data_o  = rd_data_q;
        rd_err_o   = rd_err_q;
    end

    // Ready flags are registered from next-state values so they equal the
    // current-state condition without reading as 1 while reset is held
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b0;
            rd_ready_q <= 1'b0;
            overflow_q <= 1'b0;
            bitmap_q   <= '0;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= (state_d == IDLE) && (fifo_cnt_d != FIFO_FULL);
            rd_ready_q <= (state_d == IDLE) && (fifo_cnt_d == '0);
            if (in_valid_i && !in_ready_q) overflow_q <= 1'b1;
            if (zero_acc)  bitmap_q <= '0;
            else if (pop)  bitmap_q[head_addr] <= 1'b1;
            if (zero_acc)              idx_q <= '0;
            else if (state_q == SCRUB) idx_q <= idx_q + AW'(1);
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= bitmap_q[rd_addr_i] ? mem_q[rd_addr_i] : '0;
                rd_err_q  <= ~bitmap_q[rd_addr_i];
            end
        end
    end

    // Storage without reset; the bitmap masks stale memory contents
    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[FW-1:0]] <= in_addr_i;
            fifo_data_q[wr_ptr_q[FW-1:0]] <= in_data_i;
        end
        if (pop)                   mem_q[head_addr] <= head_data;
        else if (state_q == SCRUB) mem_q[idx_q]     <= '0;
    end

`ifdef PTSTORE_FILL_COUNT_EN
    logic [AW:0] fill_count_q;
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni)                    fill_count_q <= '0;
        else if (zero_acc)                fill_count_q <= '0;
        else if (pop && !bitmap_q[head_addr]) fill_count_q <= fill_count_q + (AW+1)'(1);
    end
    assign fill_count_o = fill_count_q;
`endif

endmodule

// File: tb/tb_plaintext_store.sv
// tb/tb_plaintext_store.sv - directed self-checking bench for plaintext_store
module tb_plaintext_store;
    localparam int WIDTH = 128;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic [AW-1:0]    in_addr = '0;
    logic             in_ready, overflow;
    logic             rd_req = 1'b0;
    logic [AW-1:0]    rd_addr = '0;
    logic             rd_ready, rd_valid, rd_err;
    logic [WIDTH-1:0] rd_data;
    logic             zeroise = 1'b0;
    logic             busy;
`ifdef PTSTORE_FILL_COUNT_EN
    logic [AW:0]      fill_count;
`endif

    int compared = 0;
    int mismatched = 0;

    plaintext_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFO_DEPTH(4)) dut (
        .clock_i(clk), .reset_ni(rst_n),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_addr_i(in_addr),
        .in_ready_o(in_ready), .overflow_o(overflow),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err),
`ifdef PTSTORE_FILL_COUNT_EN
        .fill_count_o(fill_count),
`endif
        .zeroise_i(zeroise), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd_ready(input string tag);
        int n = 0;
        while (!rd_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_rd_ready_timeout"}, 128'(rd_ready), 128'(1));
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read(input string tag, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] exp_d, input logic exp_e);
        wait_rd_ready(tag);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        chk({tag, "_valid"}, 128'(rd_valid), 128'(1));
        chk({tag, "_data"}, rd_data, exp_d);
        chk({tag, "_err"}, 128'(rd_err), 128'(exp_e));
        tick();
        chk({tag, "_valid_drop"}, 128'(rd_valid), 128'(0));
    endtask

    initial begin
        int n;
        int bad;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_rd_ready", 128'(rd_ready), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_rd_data", rd_data, 128'(0));
        chk("rst_rd_err", 128'(rd_err), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        chk("post_rst_rd_ready", 128'(rd_ready), 128'(1));

        // 1: single write then read back
        push(11'd0, {WIDTH{1'b1}});
        chk("t1_rd_ready_pending", 128'(rd_ready), 128'(0));
        read("t1", 11'd0, {WIDTH{1'b1}}, 1'b0);

        // 2: unwritten entry
        read("t2", 11'd5, 128'(0), 1'b1);

        // 3: six back-to-back pushes with reads requested; drain keeps pace
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_addr  = AW'(10 + i);
            in_data  = 128'(i + 1);
            rd_req   = 1'b1;
            rd_addr  = 11'd0;
            #1;
            chk($sformatf("t3_in_ready_%0d", i), 128'(in_ready), 128'(1));
            if (i > 0) chk($sformatf("t3_rd_ready_%0d", i), 128'(rd_ready), 128'(0));
            tick();
        end
        in_valid = 1'b0;
        rd_req   = 1'b0;
        chk("t3_overflow", 128'(overflow), 128'(0));
        read("t3_a15", 11'd15, 128'(6), 1'b0);
        read("t3_a10", 11'd10, 128'(1), 1'b0);

        // 4: back-to-back overwrite, last write wins
        push(11'd1, {16{8'hA5}});
        push(11'd1, {16{8'h5A}});
        read("t4", 11'd1, {16{8'h5A}}, 1'b0);
`ifdef PTSTORE_FILL_COUNT_EN
        chk("t4_fill_count", 128'(fill_count), 128'(8));
`endif

        // 5: zeroise with a concurrent push and read request
        for (int i = 0; i < 4; i++) push(AW'(i), 128'(32'h100 + i));
        wait_rd_ready("t5_pre");
        zeroise  = 1'b1;
        rd_req   = 1'b1;
        rd_addr  = 11'd0;
        in_valid = 1'b1;
        in_addr  = 11'd7;
        in_data  = 128'hDEAD;
        #1;
        chk("t5_rd_ready_on_zeroise", 128'(rd_ready), 128'(0));
        tick();
        zeroise  = 1'b0;
        rd_req   = 1'b0;
        in_valid = 1'b0;
        chk("t5_no_read_resp", 128'(rd_valid), 128'(0));
        n = 0;
        bad = 0;
        while (busy && n < 3000) begin
            if (in_ready || rd_ready) bad++;
            in_valid = (n == 50);
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("t5_busy_cycles", 128'(n), 128'(DEPTH));
        chk("t5_ready_during_scrub", 128'(bad), 128'(0));
        chk("t5_overflow", 128'(overflow), 128'(1));
        for (int i = 0; i < 4; i++) read($sformatf("t5_a%0d", i), AW'(i), 128'(0), 1'b1);
        read("t5_a7", 11'd7, 128'(0), 1'b1);
        chk("t5_overflow_sticky", 128'(overflow), 128'(1));
`ifdef PTSTORE_FILL_COUNT_EN
        chk("t5_fill_count", 128'(fill_count), 128'(0));
`endif

        // 6: reset aborts a scrub in progress
        push(11'd9, 128'h1234);
        wait_rd_ready("t6_pre");
        zeroise = 1'b1;
        tick();
        zeroise = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("t6_busy_mid", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_busy_in_reset", 128'(busy), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_busy_after", 128'(busy), 128'(0));
        chk("t6_in_ready", 128'(in_ready), 128'(1));
        chk("t6_rd_ready", 128'(rd_ready), 128'(1));
        chk("t6_overflow_cleared", 128'(overflow), 128'(0));
        read("t6_a9", 11'd9, 128'(0), 1'b1);
        read("t6_a2047", 11'd2047, 128'(0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
